// File: rtl/d_e_reg.sv
// rtl/d_e_reg.sv - decode-to-execute pipeline register with write-back bypass
// Supports load, bubble (stall/flush), hold with a saturating hold counter, and sync reset.
module d_e_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_Stall,
  input  logic        D_Flush,
  input  logic        E_Hold,
  input  logic [31:0] D_Pc,
  input  logic [31:0] D_Instr,
  input  logic [31:0] D_RD1,
  input  logic [31:0] D_RD2,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  input  logic [4:0]  D_WA,
  input  logic [31:0] D_Ext,
  input  logic [1:0]  D_Tnew,
  input  logic        W_RegWrite,
  input  logic [4:0]  W_WA,
  input  logic [31:0] W_WD,
  output logic [31:0] E_Pc,
  output logic [31:0] E_Instr,
  output logic [31:0] E_V1,
  output logic [31:0] E_V2,
  output logic [31:0] E_Ext,
  output logic [4:0]  E_A1,
  output logic [4:0]  E_A2,
  output logic [4:0]  E_WA,
  output logic [1:0]  E_Tnew,
  output logic        E_Valid,
  output logic [3:0]  E_HoldCnt
);

  logic [31:0] r_pc       = '0;
  logic [31:0] r_instr    = '0;
  logic [31:0] r_v1       = '0;
  logic [31:0] r_v2       = '0;
  logic [31:0] r_ext      = '0;
  logic [4:0]  r_a1       = '0;
  logic [4:0]  r_a2       = '0;
  logic [4:0]  r_wa       = '0;
  logic [1:0]  r_tnew     = '0;
  logic        r_valid    = 1'b0;
  logic [3:0]  r_hold_cnt = '0;

  logic [31:0] w_v1n;
  logic [31:0] w_v2n;
  logic [1:0]  w_tnew;
  logic        w_fwd1;
  logic        w_fwd2;

  // Register 0 is hard-wired zero, so a write-back to it must never be forwarded.
  assign w_fwd1 = W_RegWrite && (W_WA != 5'd0) && (W_WA == D_A1);
  assign w_fwd2 = W_RegWrite && (W_WA != 5'd0) && (W_WA == D_A2);
  assign w_v1n  = w_fwd1 ? W_WD : D_RD1;
  assign w_v2n  = w_fwd2 ? W_WD : D_RD2;
  assign w_tnew = (D_Tnew == 2'd0) ? 2'd0 : D_Tnew - 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_v1       <= '0;
      r_v2       <= '0;
      r_ext      <= '0;
      r_a1       <= '0;
      r_a2       <= '0;
      r_wa       <= '0;
      r_tnew     <= '0;
      r_valid    <= 1'b0;
      r_hold_cnt <= '0;
    end else if (E_Hold) begin
      r_hold_cnt <= (r_hold_cnt == 4'hF) ? r_hold_cnt : r_hold_cnt + 4'd1;
    end else begin
      r_hold_cnt <= '0;
      r_pc       <= D_Pc;
      if (D_Stall || D_Flush) begin
        r_instr <= '0;
        r_v1    <= '0;
        r_v2    <= '0;
        r_ext   <= '0;
        r_a1    <= '0;
        r_a2    <= '0;
        r_wa    <= '0;
        r_tnew  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_instr <= D_Instr;
        r_v1    <= w_v1n;
        r_v2    <= w_v2n;
        r_ext   <= D_Ext;
        r_a1    <= D_A1;
        r_a2    <= D_A2;
        r_wa    <= D_WA;
        r_tnew  <= w_tnew;
        r_valid <= 1'b1;
      end
    end
  end

  assign E_Pc      = r_pc;
  assign E_Instr   = r_instr;
  assign E_V1      = r_v1;
  assign E_V2      = r_v2;
  assign E_Ext     = r_ext;
  assign E_A1      = r_a1;
  assign E_A2      = r_a2;
  assign E_WA      = r_wa;
  assign E_Tnew    = r_tnew;
  assign E_Valid   = r_valid;
  assign E_HoldCnt = r_hold_cnt;

endmodule
